// File: rtl/rr_blocking_forwarder_pkg.sv
// rr_blocking_forwarder_pkg: shared types for the round-robin blocking forwarder.
//   phases_t  : controller phase (reading a channel / writing the consumer)
//   MODE_*    : payload transform selection for the MODE parameter
package rr_forwarder_types;
   typedef enum logic {SEC_READ, SEC_WRITE} phases_t;
   localparam int MODE_PASS = 0;
   localparam int MODE_INC  = 1;
endpackage

// File: rtl/rr_blocking_forwarder_ptr_ring.sv
// rr_ptr_ring: round-robin channel pointer with one-hot decode.
//   clk, rst : clock, asynchronous active-high reset (ptr -> 0)
//   advance  : step ptr to the next channel, wrapping NUM_CH-1 -> 0
//   ptr      : current channel index
//   onehot   : 1 << ptr
module rr_ptr_ring #(
   parameter int NUM_CH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      advance,
   output logic [$clog2(NUM_CH)-1:0] ptr,
   output logic [NUM_CH-1:0]         onehot
);
   localparam int PW = $clog2(NUM_CH);

   always_ff @(posedge clk or posedge rst)
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (ptr == PW'(NUM_CH - 1)) ? '0 : ptr + PW'(1);

   assign onehot = NUM_CH'(1) << ptr;
endmodule

// File: rtl/rr_blocking_forwarder.sv
// rr_blocking_forwarder: polls NUM_CH blocking inputs round-robin and forwards
// one message at a time, tagged with its source channel, to a blocking output.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : channel payloads, channel i at [i*DATA_W +: DATA_W]
//   in_sync    : producer i offers data
//   in_notify  : one-hot (or zero) ready-to-take from channel i
//   out_data   : forwarded payload (optionally incremented, MODE=1)
//   out_ch     : source channel of out_data
//   out_sync   : consumer accepts
//   out_notify : out_data is on offer
//   xfer_cnt   : completed output transfers, wraps
module rr_blocking_forwarder
   import rr_forwarder_types::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int MODE   = 0,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*DATA_W-1:0]  in_data,
   input  logic [NUM_CH-1:0]         in_sync,
   output logic [NUM_CH-1:0]         in_notify,
   output logic [DATA_W-1:0]         out_data,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   input  logic                      out_sync,
   output logic                      out_notify,
   output logic [CNT_W-1:0]          xfer_cnt
);
   localparam int PW = $clog2(NUM_CH);

   phases_t           phase, phase_nxt;
   logic [PW-1:0]     ptr;
   logic [NUM_CH-1:0] ptr_dec;
   logic              take, give;
   logic [DATA_W-1:0] sel;

   // The pointer keeps moving every read cycle: on a miss it polls the next
   // channel, on a hit it already points past the served channel so the
   // search resumes there once the write completes.
   rr_ptr_ring #(.NUM_CH(NUM_CH)) u_ring (
      .clk     (clk),
      .rst     (rst),
      .advance (phase == SEC_READ),
      .ptr     (ptr),
      .onehot  (ptr_dec)
   );

   always_comb begin
      take      = (phase == SEC_READ) && in_sync[ptr];
      give      = (phase == SEC_WRITE) && out_sync;
      phase_nxt = take ? SEC_WRITE : give ? SEC_READ : phase;
      sel       = in_data[int'(ptr)*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst)
         phase <= SEC_READ;
      else
         phase <= phase_nxt;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_data <= '0;
         out_ch   <= '0;
         xfer_cnt <= '0;
      end else begin
         if (take) begin
            out_data <= (MODE == MODE_INC) ? sel + DATA_W'(1) : sel;
            out_ch   <= ptr;
         end
         if (give)
            xfer_cnt <= xfer_cnt + CNT_W'(1);
      end

   // Both notifies decode from the phase register, so they are mutually exclusive.
   assign in_notify  = (phase == SEC_READ) ? ptr_dec : '0;
   assign out_notify = (phase == SEC_WRITE);
endmodule
